shift_out_driver: RTL

SHIFT_OUT_DRIVER -- requirements
Module: shift_out_driver

---
 rtl/shift_out_driver.sv | 136 +++++++++++++
 1 files changed

// File: rtl/shift_out_driver.sv
// Serial shift-out driver for an external shift/storage register pair (595-style).
// Each transfer shifts WIDTH bits with a DIV-cycle setup and clock phase per bit, then a DIV-cycle latch strobe.
module shift_out_driver #(
    parameter int WIDTH     = 40,
    parameter int DIV       = 20,
    parameter bit LSB_FIRST = 1'b1,
    parameter bit AUTO_TRIG = 1'b1
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_input,
    input  logic             load,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             shift_pulse,
    output logic             latch_clk,
    output logic             sdata
);

    localparam int               IDX_W     = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [7:0]       PHASE_END = 8'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        CLOCK,
        LATCH
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       phase_q, phase_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] last_word_q, last_word_d;
    logic             pending_q, pending_d;
    logic             done_q, done_d;
    logic             start;
    logic             phase_end;
    logic             cur_bit;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            index_q     <= '0;
            shadow_q    <= '0;
            last_word_q <= '0;
            pending_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            index_q     <= index_d;
            shadow_q    <= shadow_d;
            last_word_q <= last_word_d;
            pending_q   <= pending_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        index_d     = index_q;
        shadow_d    = shadow_q;
        last_word_d = last_word_q;
        pending_d   = pending_q;
        done_d      = 1'b0;

        phase_end = (phase_q == PHASE_END);
        start     = load || pending_q || (AUTO_TRIG && (data_input != last_word_q));

        // Requests arriving mid-transfer collapse into a single pending flag.
        if (load && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d  = data_input;
                    pending_d = 1'b0;
                    index_d   = '0;
                    phase_d   = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    phase_d = '0;
                    state_d = CLOCK;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            CLOCK: begin
                if (phase_end) begin
                    phase_d = '0;
                    if (index_q == LAST_IDX) begin
                        state_d = LATCH;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = SETUP;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            LATCH: begin
                if (phase_end) begin
                    phase_d     = '0;
                    last_word_d = shadow_q;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from the state flops so an async reset clears them at once.
    always_comb begin
        cur_bit     = LSB_FIRST ? shadow_q[index_q] : shadow_q[LAST_IDX - index_q];
        shift_pulse = (state_q == CLOCK);
        latch_clk   = (state_q == LATCH);
        busy        = (state_q != IDLE);
        sdata       = ((state_q == SETUP) || (state_q == CLOCK)) ? cur_bit : 1'b0;
        ready       = (state_q == IDLE) && !pending_q;
        done        = done_q;
    end

endmodule
